// File: rtl/bcam_ctrl_pkg.sv
// Shared types and helpers for the board-side BCAM command controller.
package bcam_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WWAIT,
        MATCH,
        MWAIT,
        CAPT,
        CLEAR,
        CWAIT
    } state_t;

    // Address width of a CAM with the given depth; never narrower than one bit.
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // LED field offsets: the match address occupies [aw-1:0].
    function automatic int unsigned led_match_bit(input int unsigned aw);
        return aw;
    endfunction

    function automatic int unsigned led_full_bit(input int unsigned aw);
        return aw + 1;
    endfunction

    function automatic int unsigned led_wptr_lsb(input int unsigned aw);
        return aw + 2;
    endfunction

endpackage

// File: rtl/bcam_btn_sync.sv
// Button conditioner: 2-FF synchroniser, stable-count debounce, one-cycle rising-edge pulse.
module bcam_btn_sync #(
    parameter int unsigned DBNC_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned CNTW = $clog2(DBNC_CYC);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DBNC_CYC - 1);

    logic            s1;
    logic            s2;
    logic            db;
    logic [CNTW-1:0] cnt;

    // The debounced level follows the synchronised input only after DBNC_CYC equal samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            db    <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            pulse <= 1'b0;
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                db    <= s2;
                pulse <= s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcam_board_ctrl.sv
// Board command controller for an external binary CAM: write / match / clear-all sequencing.
// Optional BCAM_HITCNT_EN adds a 16-bit saturating match-hit counter on port hit_cnt.
module bcam_board_ctrl
    import bcam_ctrl_pkg::*;
#(
    parameter int unsigned     CAMD     = 256,
    parameter int unsigned     CAMW     = 16,
    parameter int unsigned     LEDW     = 16,
    parameter int unsigned     DBNC_CYC = 1000000,
    parameter int unsigned     WLAT     = 2,
    parameter int unsigned     MLAT     = 3,
    parameter logic [CAMW-1:0] CLR_PATT = '0,
    localparam int unsigned    ADDRW    = addr_w(CAMD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CAMW-1:0]  sw,
    input  logic             btn_wr,
    input  logic             btn_match,
    input  logic             btn_clr,
    output logic             cam_wEnb,
    output logic [ADDRW-1:0] cam_wAddr,
    output logic [CAMW-1:0]  cam_wPatt,
    output logic [CAMW-1:0]  cam_mPatt,
    input  logic             cam_match,
    input  logic [ADDRW-1:0] cam_mAddr,
    output logic             busy,
    output logic             full,
    output logic [LEDW-1:0]  led
`ifdef BCAM_HITCNT_EN
    ,
    output logic [15:0]      hit_cnt
`endif
);

    localparam int unsigned LATW = $clog2(max3(WLAT, MLAT, CAMD) + 1);
    localparam int unsigned MB   = led_match_bit(ADDRW);
    localparam int unsigned FB   = led_full_bit(ADDRW);
    localparam int unsigned WB   = led_wptr_lsb(ADDRW);
    localparam int unsigned WPL  = (LEDW - ADDRW - 2 < ADDRW) ? (LEDW - ADDRW - 2) : ADDRW;
    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(CAMD - 1);

    state_t           state;
    logic [LATW-1:0]  lat_cnt;
    logic [ADDRW-1:0] wptr;
    logic             match_r;
    logic [ADDRW-1:0] maddr_r;
    logic             wr_p;
    logic             match_p;
    logic             clr_p;

    bcam_btn_sync #(.DBNC_CYC(DBNC_CYC)) u_sync_wr (
        .clk(clk), .rst(rst), .btn(btn_wr), .pulse(wr_p)
    );

    bcam_btn_sync #(.DBNC_CYC(DBNC_CYC)) u_sync_match (
        .clk(clk), .rst(rst), .btn(btn_match), .pulse(match_p)
    );

    bcam_btn_sync #(.DBNC_CYC(DBNC_CYC)) u_sync_clr (
        .clk(clk), .rst(rst), .btn(btn_clr), .pulse(clr_p)
    );

    // Command sequencer; button pulses outside IDLE are simply ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            full      <= 1'b0;
            wptr      <= '0;
            lat_cnt   <= '0;
            cam_wEnb  <= 1'b0;
            cam_wAddr <= '0;
            cam_wPatt <= '0;
            cam_mPatt <= '0;
            match_r   <= 1'b0;
            maddr_r   <= '0;
`ifdef BCAM_HITCNT_EN
            hit_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (clr_p) begin
                        state     <= CLEAR;
                        busy      <= 1'b1;
                        cam_wEnb  <= 1'b1;
                        cam_wAddr <= '0;
                        cam_wPatt <= CLR_PATT;
                    end else if (wr_p) begin
                        state     <= WRITE;
                        busy      <= 1'b1;
                        cam_wEnb  <= 1'b1;
                        cam_wAddr <= wptr;
                        cam_wPatt <= sw;
                    end else if (match_p) begin
                        state     <= MATCH;
                        busy      <= 1'b1;
                        cam_mPatt <= sw;
                    end
                end
                WRITE: begin
                    cam_wEnb <= 1'b0;
                    lat_cnt  <= LATW'(WLAT - 1);
                    state    <= WWAIT;
                    if (wptr == LAST_ADDR) begin
                        wptr <= '0;
                        full <= 1'b1;
                    end else begin
                        wptr <= wptr + 1'b1;
                    end
                end
                WWAIT: begin
                    if (lat_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                MATCH: begin
                    lat_cnt <= LATW'(MLAT - 1);
                    state   <= MWAIT;
                end
                MWAIT: begin
                    if (lat_cnt == '0) begin
                        state <= CAPT;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                CAPT: begin
                    match_r <= cam_match;
                    maddr_r <= cam_match ? cam_mAddr : '0;
`ifdef BCAM_HITCNT_EN
                    if (cam_match && (hit_cnt != 16'hFFFF)) begin
                        hit_cnt <= hit_cnt + 16'd1;
                    end
`endif
                    state   <= IDLE;
                    busy    <= 1'b0;
                end
                CLEAR: begin
                    if (cam_wAddr == LAST_ADDR) begin
                        cam_wEnb <= 1'b0;
                        lat_cnt  <= LATW'(WLAT - 1);
                        state    <= CWAIT;
                    end else begin
                        cam_wAddr <= cam_wAddr + 1'b1;
                    end
                end
                CWAIT: begin
                    if (lat_cnt == '0) begin
                        wptr    <= '0;
                        full    <= 1'b0;
                        match_r <= 1'b0;
                        maddr_r <= '0;
`ifdef BCAM_HITCNT_EN
                        hit_cnt <= '0;
`endif
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    cam_wEnb <= 1'b0;
                end
            endcase
        end
    end

    // LED map: match address, match flag, full flag, then as many wptr LSBs as fit.
    always_comb begin
        led                = '0;
        led[ADDRW-1:0]     = maddr_r;
        led[MB]            = match_r;
        led[FB]            = full;
        led[WB +: WPL]     = wptr[WPL-1:0];
    end

endmodule
